bus_demux8_reg: RTL and testbench
=================================

Name: bus_demux8_reg

Overview:
- Registered 1-to-8 bus demultiplexer: the write/steering counterpart of the 8:1 bus read mux.
- Accepts one WIDTH-bit word per handshake and holds it in a single-entry pipeline register.
- Delivers the word to one selected destination lane, or to all 8 lanes in broadcast mode, using independent per-lane valid/ready handshakes.
- Used to fan a single producer bus (e.g. writeback or forwarding data) out to 8 consumers.

Parameters:
- WIDTH, 64, data bus width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to deliver.
- in_sel  input  3  destination lane index 0..7; ignored when in_bcast=1.
- in_bcast  input  1  1 = deliver to all 8 lanes.
- in_valid  input  1  producer offers in_data/in_sel/in_bcast.
- in_ready  output  1  block accepts the word this cycle.
- out  output  [7:0][WIDTH]  per-lane data; lane j is out[j].
- out_valid  output  8  per-lane valid.
- out_ready  input  8  per-lane consumer ready.
- busy  output  1  any lane still pending.

Behaviour:
- State: data_q[WIDTH] and pend_q[7:0]. The block is empty when pend_q == 0.
- Reset (async, reset_n=0):
  - data_q=0, pend_q=0.
  - Therefore out_valid=0, every out[j]=0, busy=0, in_ready=1.
  - Asserting reset mid-transfer discards the held word and all pending lanes immediately, without waiting for a clock edge.
- Outputs:
  - out_valid = pend_q.
  - out[j] = data_q when pend_q[j]=1, else all zeros.
  - busy = |pend_q.
  - out_valid and out are registered only; they never depend combinationally on out_ready.
- Lane transfer:
  - acc[j] = pend_q[j] & out_ready[j].
  - A lane completes at the clock edge where acc[j]=1, and pend_q[j] clears at that edge.
  - out_ready[j] on a non-pending lane is ignored.
- in_ready = ((pend_q & ~acc) == 0). It is high when the block is empty, or when every still-pending lane completes this cycle.
  - This is a deliberate combinational path from out_ready to in_ready; it gives full throughput.
- Load, when in_valid & in_ready at an edge:
  - data_q <= in_data.
  - pend_q <= in_bcast ? 8'hFF : onehot(in_sel).
  - A load in the same cycle as the final lane completion replaces the old word seamlessly; the new pending mask wins.
- Latency: a word accepted at edge N is valid on its lane(s) from edge N to the next edge. Throughput is 1 word/cycle when the target lanes are always ready.
- Hold rule: while pend_q[j]=1, out[j] and out_valid[j] are stable until lane j completes.
- Broadcast:
  - Lanes complete independently, in any order and at any cycles.
  - A lane that has accepted drops out_valid; the others keep offering the same data.
  - The next word is accepted only once all 8 lanes have completed. A stalled lane back-pressures the producer.
- No internal FSM beyond the pend_q mask: state EMPTY when pend_q=0, PENDING otherwise. Transitions are as above; no error states.
- in_valid low: no load, no state change except lane completions.

Test Plan:
- Reset with in_valid=1 and random inputs: out_valid=8'h00, all out=0, in_ready=1, busy=0. After release, send in_data=16'h1736, in_sel=3, out_ready=8'hFF (WIDTH=16): next cycle out_valid=8'h08, out[3]=16'h1736, all other lanes 0.
- Sweep sel 0..7 with out_ready=8'hFF and back-to-back in_valid, data 16'h0D6B, 16'hDC8D, ...: exactly one lane valid each cycle, out[i]=data_i, and in_ready stays 1 throughout.
- Unicast to lane 5 (16'h3AB4) with out_ready[5]=0 for 3 cycles: out_valid=8'h20, data stable, and in_ready=0 for those cycles. Raising out_ready[5] gives in_ready=1 that same cycle, and a queued word (sel=2, 16'h864A) appears on lane 2 on the following cycle.
- Broadcast 16'hCA88 with out_ready pulsed lane-by-lane 7→0, one lane per cycle: out_valid steps FF, 7F, 3F, … , 01, 00. in_ready=1 only in the cycle lane 0 accepts; all lanes carry 16'hCA88 while valid.
- Reset mid-broadcast with out_valid=8'h0F: out_valid=0 and out=0 immediately, without a clock edge. After release, in_ready=1 and the old word is never re-delivered.
- Simultaneous events: a pending unicast on lane 1 completes while a new broadcast is offered in the same cycle. The result is out_valid=8'hFF with the new data; lane 1 never sees a 1-cycle gap or stale data.

Source files
------------

// File: rtl/bus_demux8_reg.sv
// Registered 1-to-8 bus demux: one word held, delivered to one lane or broadcast to all 8.
// Latency: word accepted at edge N is offered on its lane(s) right after edge N.
// Backpressure: in_ready drops while any lane is still pending and not completing this cycle.
module bus_demux8_reg #(
    parameter int WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [2:0]            in_sel,
    input  logic                  in_bcast,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0][WIDTH-1:0] out,
    output logic [7:0]            out_valid,
    input  logic [7:0]            out_ready,
    output logic                  busy
);

    logic [WIDTH-1:0] data_q;
    logic [7:0]       pend_q;
    logic [7:0]       acc;
    logic [7:0]       sel_mask;
    logic             load;

    assign acc      = pend_q & out_ready;
    // Combinational from out_ready so the last completing lane lets the next word in the same cycle.
    assign in_ready = ((pend_q & ~acc) == 8'h00);
    assign load     = in_valid & in_ready;
    assign sel_mask = 8'h01 << in_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            pend_q <= 8'h00;
        end else if (load) begin
            data_q <= in_data;
            pend_q <= in_bcast ? 8'hFF : sel_mask;
        end else begin
            pend_q <= pend_q & ~acc;
        end
    end

    assign out_valid = pend_q;
    assign busy      = |pend_q;

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            out[j] = pend_q[j] ? data_q : '0;
        end
    end

endmodule

// File: tb/tb_bus_demux8_reg.sv
// Directed bench for bus_demux8_reg at WIDTH=16 with hand-computed expectations.
module tb_bus_demux8_reg;

    logic             clk;
    logic             reset_n;
    logic [15:0]      in_data;
    logic [2:0]       in_sel;
    logic             in_bcast;
    logic             in_valid;
    logic             in_ready;
    logic [7:0][15:0] out;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    bus_demux8_reg #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected lane bus: data replicated onto every lane whose mask bit is set.
    function automatic logic [127:0] rep(input logic [15:0] d, input logic [7:0] m);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 8; j++)
            if (m[j]) r[j*16 +: 16] = d;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [15:0] sweep [8];
    logic [7:0]  mask;

    initial begin
        sweep[0] = 16'h0D6B; sweep[1] = 16'hDC8D; sweep[2] = 16'h5A21; sweep[3] = 16'h9E47;
        sweep[4] = 16'h13F0; sweep[5] = 16'h7C3D; sweep[6] = 16'hB2E9; sweep[7] = 16'h4418;

        // Reset with busy-looking inputs
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'($urandom);
        in_sel    = 3'($urandom);
        in_bcast  = 1'($urandom);
        out_ready = 8'($urandom);
        tick();
        tick();
        check("rst_out_valid", 128'(out_valid), 128'h00);
        check("rst_out", out, '0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_busy", 128'(busy), 128'd0);

        reset_n   = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h1736;
        in_sel    = 3'd3;
        in_bcast  = 1'b0;
        out_ready = 8'hFF;
        tick();
        in_valid = 1'b0;
        check("first_out_valid", 128'(out_valid), 128'h08);
        check("first_out", out, rep(16'h1736, 8'h08));
        check("first_busy", 128'(busy), 128'd1);
        tick();
        check("first_drain", 128'(out_valid), 128'h00);

        // Back-to-back sweep over all lanes
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'(i);
            in_data  = sweep[i];
            #1;
            check($sformatf("sweep_in_ready_%0d", i), 128'(in_ready), 128'd1);
            tick();
            check($sformatf("sweep_valid_%0d", i), 128'(out_valid), 128'(8'h01 << i));
            check($sformatf("sweep_out_%0d", i), out, rep(sweep[i], 8'h01 << i));
        end
        in_valid = 1'b0;
        tick();
        check("sweep_drain", 128'(out_valid), 128'h00);

        // Unicast stall on lane 5 with a queued word behind it
        out_ready = 8'hDF;
        in_valid  = 1'b1;
        in_sel    = 3'd5;
        in_data   = 16'h3AB4;
        tick();
        in_sel  = 3'd2;
        in_data = 16'h864A;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall_valid_%0d", c), 128'(out_valid), 128'h20);
            check($sformatf("stall_out_%0d", c), out, rep(16'h3AB4, 8'h20));
            check($sformatf("stall_in_ready_%0d", c), 128'(in_ready), 128'd0);
            tick();
        end
        out_ready = 8'hFF;
        #1;
        check("stall_release_in_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        check("queued_valid", 128'(out_valid), 128'h04);
        check("queued_out", out, rep(16'h864A, 8'h04));
        tick();
        check("queued_drain", 128'(out_valid), 128'h00);

        // Broadcast drained lane 7 down to lane 0
        out_ready = 8'h00;
        in_valid  = 1'b1;
        in_bcast  = 1'b1;
        in_data   = 16'hCA88;
        tick();
        in_valid = 1'b0;
        in_bcast = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            mask = 8'hFF >> (7 - k);
            check($sformatf("bc_valid_%0d", k), 128'(out_valid), 128'(mask));
            check($sformatf("bc_out_%0d", k), out, rep(16'hCA88, mask));
            out_ready = 8'h01 << k;
            #1;
            check($sformatf("bc_in_ready_%0d", k), 128'(in_ready), 128'(k == 0));
            tick();
        end
        out_ready = 8'h00;
        check("bc_done", 128'(out_valid), 128'h00);

        // Reset in the middle of a broadcast
        in_valid = 1'b1;
        in_bcast = 1'b1;
        in_data  = 16'h5EED;
        tick();
        in_valid = 1'b0;
        in_bcast = 1'b0;
        for (int k = 7; k >= 4; k--) begin
            out_ready = 8'h01 << k;
            tick();
        end
        out_ready = 8'h00;
        check("mid_pre_valid", 128'(out_valid), 128'h0F);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'h00);
        check("mid_rst_out", out, '0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        tick();
        reset_n = 1'b1;
        #1;
        check("mid_post_in_ready", 128'(in_ready), 128'd1);
        tick();
        check("mid_post_valid", 128'(out_valid), 128'h00);
        check("mid_post_out", out, '0);

        // Lane 1 completes while a broadcast loads in the same cycle
        in_valid = 1'b1;
        in_sel   = 3'd1;
        in_data  = 16'h1111;
        tick();
        check("sim_pre_valid", 128'(out_valid), 128'h02);
        check("sim_pre_out", out, rep(16'h1111, 8'h02));
        in_bcast  = 1'b1;
        in_data   = 16'h2222;
        out_ready = 8'h02;
        #1;
        check("sim_in_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid  = 1'b0;
        in_bcast  = 1'b0;
        out_ready = 8'h00;
        check("sim_valid", 128'(out_valid), 128'hFF);
        check("sim_out", out, rep(16'h2222, 8'hFF));
        out_ready = 8'hFF;
        tick();
        check("sim_drain", 128'(out_valid), 128'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
